pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  - Generic multi-channel pipeline register for any boundary of the 5-stage MIPS pipe.
//    Replaces per-boundary hand-written latches.
//  - Carries NUM_CH channels. Each channel has a CH_W-bit payload and a 1-bit write enable
//    (examples: GPR write, HI/LO write, LLbit write, CP0 write).
//  - Honours the ctrl stall vector: pass, bubble or hold. Adds a flush input.
// PARAMETERS
//  NUM_CH    4   number of payload channels
//  CH_W      32  payload width per channel, in bits
//  STOP_W    6   width of the ctrl stall vector
//  STAGE     4   stop[] bit index owned by this register; stop[STAGE+1] is the downstream stage
//  CLR_DATA  1   1: bubble/flush zero the payload; 0: payload holds, only enables clear
//  TAG_W     5   per-channel destination tag width (reg / CP0 address)
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active-high
//  stop       in   STOP_W        stall vector from ctrl; 1 = stall
//  flush      in   1             exception/branch flush; 1 = kill the stage contents
//  in_we      in   NUM_CH        per-channel write enable from upstream
//  in_tag     in   NUM_CH*TAG_W  per-channel tags, channel k at [k*TAG_W +: TAG_W]
//  in_data    in   NUM_CH*CH_W   per-channel payload, channel k at [k*CH_W +: CH_W]
//  out_we     out  NUM_CH        registered enables
//  out_tag    out  NUM_CH*TAG_W  registered tags
//  out_data   out  NUM_CH*CH_W   registered payload
//  out_valid  out  1             1 = stage holds a real instruction (set on load, cleared on bubble/flush)
//  bubble_cnt out  16            only with PIPE_STAGE_PERF_EN
//  hold_cnt   out  16            only with PIPE_STAGE_PERF_EN
// BEHAVIOUR
//  - All state updates on posedge clk only. Latency is 1 cycle, input to output. No combinational in->out path.
//  - Define s_here = stop[STAGE].
//  - Define s_next = stop[STAGE+1] when STAGE < STOP_W-1; otherwise s_next = 0.
//  - Per-cycle priority, highest first:
//    1. rst=1: out_we=0, out_tag=0, out_data=0, out_valid=0.
//    2. flush=1: out_we=0, out_valid=0.
//       - CLR_DATA=1: out_tag=0, out_data=0.
//       - CLR_DATA=0: out_tag and out_data hold.
//    3. s_here=1, s_next=0 (BUBBLE): same clearing as flush.
//    4. s_here=0 (PASS): load all out_* from in_*; out_valid=1.
//    5. s_here=1, s_next=1 (HOLD): every output keeps its value.
//  - flush wins over HOLD, so a stalled stage is still killed.
//  - rst wins over everything. Asserting rst mid-stall clears the stage, and the next cycle
//    follows the rules above.
//  - Channels are independent lanes. No cross-channel arithmetic.
//  - Enables are copied bit-exact; out_we[k]=1 requires in_we[k]=1 at the last PASS.
//  - stop bits above STAGE+1 and below STAGE are ignored.
//  - STAGE >= STOP_W is illegal. Elaboration must fail, via a generate-time error.
// CONFIGURATION
//  - Macro PIPE_STAGE_PERF_EN defined:
//    - bubble_cnt increments on each BUBBLE cycle.
//    - hold_cnt increments on each HOLD cycle.
//    - A flush cycle increments neither counter.
//    - Both are 16-bit, saturate at 16'hFFFF (no wrap), and are cleared to 0 by rst.
//  - Macro undefined: both counter ports and their logic are absent. Datapath behaviour is identical.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_we=4'hF, in_data all 0xDEADBEEF
//     -> out_we=0, out_data=0, out_tag=0, out_valid=0.
//  2. Pass: stop=6'b000000, in_we=4'b1011, ch0=0x00001234, tag0=5'd7
//     -> next edge: out_we=4'b1011, ch0=0x00001234, tag0=7, out_valid=1.
//  3. Bubble: stop=6'b010000 after a load
//     -> out_we=0, out_valid=0.
//     -> CLR_DATA=1: out_data=0. CLR_DATA=0: out_data keeps 0x00001234.
//  4. Hold: stop=6'b110000 for 3 cycles while inputs toggle
//     -> all outputs unchanged; stop back to 0 -> the current input is loaded on the next edge.
//  5. Flush: flush=1 with stop=0 and in_we=4'hF -> out_we=0, out_valid=0.
//     Flush=1 during HOLD -> cleared. Flush=1 with rst=1 -> reset values.
//  6. Perf (PIPE_STAGE_PERF_EN): 3 BUBBLE cycles, then 70000 HOLD cycles
//     -> bubble_cnt=3, hold_cnt=16'hFFFF. Then rst -> both 0.
//     Also: STAGE=5 with stop=6'b100000 gives BUBBLE, since s_next is forced to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: multi-channel pipeline register with pass/bubble/hold/flush control.
// Defining PIPE_STAGE_PERF_EN adds saturating bubble and hold counters.
module pipe_stage_reg #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 32,
    parameter int STOP_W   = 6,
    parameter int STAGE    = 4,
    parameter int CLR_DATA = 1,
    parameter int TAG_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STOP_W-1:0]         stop,
    input  logic                      flush,
    input  logic [NUM_CH-1:0]         in_we,
    input  logic [NUM_CH*TAG_W-1:0]   in_tag,
    input  logic [NUM_CH*CH_W-1:0]    in_data,
    output logic [NUM_CH-1:0]         out_we,
    output logic [NUM_CH*TAG_W-1:0]   out_tag,
    output logic [NUM_CH*CH_W-1:0]    out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic                      out_valid,
    output logic [15:0]               bubble_cnt,
    output logic [15:0]               hold_cnt
`else
    output logic                      out_valid
`endif
);
    localparam bit HAS_NEXT = STAGE < STOP_W - 1;
    localparam int SH       = (STAGE < STOP_W) ? STAGE : 0;
    localparam int SN       = HAS_NEXT ? STAGE + 1 : SH;

    generate
        if (STAGE >= STOP_W) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must be below STOP_W");
        end
    endgenerate

    logic s_here, s_next, kill;
    logic unused_stop_bits;

    // The last stage has no downstream owner, so its stall always means bubble.
    assign s_here           = stop[SH];
    assign s_next           = HAS_NEXT && stop[SN];
    assign kill             = flush || (s_here && !s_next);
    assign unused_stop_bits = ^stop;

    // Stage contents: reset, kill (flush/bubble), load on pass, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_we    <= '0;
            out_tag   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (kill) begin
            out_we    <= '0;
            out_valid <= 1'b0;
            if (CLR_DATA != 0) begin
                out_tag  <= '0;
                out_data <= '0;
            end
        end else if (!s_here) begin
            out_we    <= in_we;
            out_tag   <= in_tag;
            out_data  <= in_data;
            out_valid <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating stall counters; flush cycles are neither bubble nor hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else if (!flush && s_here) begin
            if (!s_next && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
            if (s_next && hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: random and directed checks of two pipe_stage_reg instances against a behavioural model.
module tb_pipe_stage_reg;
    logic         clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [5:0]   stop = '0;
    logic [3:0]   in_we = '0;
    logic [19:0]  in_tag = '0;
    logic [127:0] in_data = '0;
    logic [3:0]   o_we [2];
    logic [19:0]  o_tag [2];
    logic [127:0] o_data [2];
    logic         o_valid [2];
    logic [3:0]   m_we [2];
    logic [19:0]  m_tag [2];
    logic [127:0] m_data [2];
    logic         m_valid [2];
    int           checks = 0, failures = 0;
    bit           live = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]  o_bc [2], o_hc [2];
    int           m_bc [2], m_hc [2];
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.STAGE(4), .CLR_DATA(1)) u0 (
        .clk(clk), .rst(rst), .stop(stop), .flush(flush),
        .in_we(in_we), .in_tag(in_tag), .in_data(in_data),
        .out_we(o_we[0]), .out_tag(o_tag[0]), .out_data(o_data[0]),
`ifdef PIPE_STAGE_PERF_EN
        .bubble_cnt(o_bc[0]), .hold_cnt(o_hc[0]),
`endif
        .out_valid(o_valid[0])
    );

    pipe_stage_reg #(.STAGE(5), .CLR_DATA(0)) u1 (
        .clk(clk), .rst(rst), .stop(stop), .flush(flush),
        .in_we(in_we), .in_tag(in_tag), .in_data(in_data),
        .out_we(o_we[1]), .out_tag(o_tag[1]), .out_data(o_data[1]),
`ifdef PIPE_STAGE_PERF_EN
        .bubble_cnt(o_bc[1]), .hold_cnt(o_hc[1]),
`endif
        .out_valid(o_valid[1])
    );

    // 0 reset, 1 flush, 2 pass, 3 hold, 4 bubble
    function automatic int mode(int st, logic r, logic [5:0] s, logic f);
        int sv = int'(s);
        if (r) return 0;
        if (f) return 1;
        if (((sv >> st) & 1) == 0) return 2;
        return (((sv >> (st + 1)) & 1) != 0) ? 3 : 4;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            case (mode(d == 0 ? 4 : 5, rst, stop, flush))
                0: begin
                    m_we[d] <= '0; m_tag[d] <= '0; m_data[d] <= '0; m_valid[d] <= 1'b0;
                end
                1, 4: begin
                    m_we[d] <= '0; m_valid[d] <= 1'b0;
                    if (d == 0) begin m_tag[d] <= '0; m_data[d] <= '0; end
                end
                2: begin
                    m_we[d] <= in_we; m_tag[d] <= in_tag; m_data[d] <= in_data; m_valid[d] <= 1'b1;
                end
                default: ;
            endcase
`ifdef PIPE_STAGE_PERF_EN
            case (mode(d == 0 ? 4 : 5, rst, stop, flush))
                0: begin m_bc[d] <= 0; m_hc[d] <= 0; end
                3: m_hc[d] <= (m_hc[d] + 1 > 65535) ? 65535 : m_hc[d] + 1;
                4: m_bc[d] <= (m_bc[d] + 1 > 65535) ? 65535 : m_bc[d] + 1;
                default: ;
            endcase
`endif
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({o_we[d], o_tag[d], o_data[d], o_valid[d]} !== {m_we[d], m_tag[d], m_data[d], m_valid[d]}) begin
                    failures++;
                    $display("FAIL model dut%0d t=%0t got we=%h tag=%h data=%h valid=%b exp we=%h tag=%h data=%h valid=%b",
                             d, $time, o_we[d], o_tag[d], o_data[d], o_valid[d], m_we[d], m_tag[d], m_data[d], m_valid[d]);
                end
`ifdef PIPE_STAGE_PERF_EN
                checks++;
                if (o_bc[d] !== 16'(m_bc[d]) || o_hc[d] !== 16'(m_hc[d])) begin
                    failures++;
                    $display("FAIL perf_model dut%0d got bubble=%0d hold=%0d exp bubble=%0d hold=%0d",
                             d, o_bc[d], o_hc[d], m_bc[d], m_hc[d]);
                end
`endif
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] s, input logic f,
                        input logic [3:0] we, input logic [19:0] tg, input logic [127:0] dt);
        @(negedge clk);
        rst = r; stop = s; flush = f; in_we = we; in_tag = tg; in_data = dt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        step(1, 6'd0, 0, 4'hF, 20'hFFFFF, {4{32'hDEADBEEF}});
        live = 1'b1;
        step(1, 6'd0, 0, 4'hF, 20'hFFFFF, {4{32'hDEADBEEF}});
        chk("rst_we", 128'(o_we[0]), 128'h0);
        chk("rst_tag", 128'(o_tag[0]), 128'h0);
        chk("rst_data", o_data[0], 128'h0);
        chk("rst_valid", 128'(o_valid[0]), 128'h0);

        step(0, 6'd0, 0, 4'b1011, {5'd4, 5'd3, 5'd2, 5'd7},
             {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001, 32'h00001234});
        chk("pass_we", 128'(o_we[0]), 128'hB);
        chk("pass_d0", 128'(o_data[0][31:0]), 128'h1234);
        chk("pass_t0", 128'(o_tag[0][4:0]), 128'd7);
        chk("pass_valid", 128'(o_valid[0]), 128'h1);
        chk("pass_we_s5", 128'(o_we[1]), 128'hB);

        step(0, 6'b100000, 0, 4'hF, 20'hFFFFF, {4{32'h5555AAAA}});
        chk("last_bubble_we", 128'(o_we[1]), 128'h0);
        chk("last_bubble_valid", 128'(o_valid[1]), 128'h0);
        chk("last_bubble_keep_d0", 128'(o_data[1][31:0]), 128'h1234);
        chk("upstream_pass_d0", 128'(o_data[0][31:0]), 128'h5555AAAA);

        step(0, 6'b010000, 0, 4'hF, 20'hFFFFF, rnd128());
        chk("bubble_we", 128'(o_we[0]), 128'h0);
        chk("bubble_valid", 128'(o_valid[0]), 128'h0);
        chk("bubble_data", o_data[0], 128'h0);

        step(0, 6'd0, 0, 4'b0110, 20'h12345, {4{32'h11112222}});
        repeat (3) begin
            step(0, 6'b110000, 0, 4'($urandom), 20'($urandom), rnd128());
            chk("hold_we", 128'(o_we[0]), 128'h6);
            chk("hold_tag", 128'(o_tag[0]), 128'h12345);
            chk("hold_data", o_data[0], {4{32'h11112222}});
            chk("hold_valid", 128'(o_valid[0]), 128'h1);
        end
        step(0, 6'd0, 0, 4'b1001, 20'hABCDE, {4{32'hFEEDF00D}});
        chk("resume_we", 128'(o_we[0]), 128'h9);
        chk("resume_data", o_data[0], {4{32'hFEEDF00D}});

        step(0, 6'd0, 1, 4'hF, 20'hFFFFF, rnd128());
        chk("flush_we", 128'(o_we[0]), 128'h0);
        chk("flush_valid", 128'(o_valid[0]), 128'h0);
        step(0, 6'd0, 0, 4'hF, 20'h54321, {4{32'h0BADCAFE}});
        step(0, 6'b110000, 1, 4'hF, 20'hFFFFF, rnd128());
        chk("flush_hold_we", 128'(o_we[0]), 128'h0);
        chk("flush_hold_valid", 128'(o_valid[0]), 128'h0);
        chk("flush_hold_data", o_data[0], 128'h0);
        step(0, 6'd0, 0, 4'hF, 20'h54321, {4{32'h0BADCAFE}});
        step(1, 6'd0, 1, 4'hF, 20'hFFFFF, rnd128());
        chk("flush_rst_data_s5", o_data[1], 128'h0);
        chk("flush_rst_we", 128'(o_we[0]), 128'h0);

        repeat (600)
            step($urandom_range(0, 31) == 0, 6'($urandom), $urandom_range(0, 7) == 0,
                 4'($urandom), 20'($urandom), rnd128());

`ifdef PIPE_STAGE_PERF_EN
        step(1, 6'd0, 0, 4'h0, 20'h0, 128'h0);
        repeat (3) step(0, 6'b010000, 0, 4'hF, 20'h0, rnd128());
        repeat (65540) step(0, 6'b110000, 0, 4'hF, 20'h0, 128'h0);
        chk("perf_bubble", 128'(o_bc[0]), 128'd3);
        chk("perf_hold_sat", 128'(o_hc[0]), 128'hFFFF);
        chk("perf_s5_bubble_sat", 128'(o_bc[1]), 128'hFFFF);
        step(1, 6'b110000, 0, 4'hF, 20'h0, 128'h0);
        chk("perf_rst_bubble", 128'(o_bc[0]), 128'd0);
        chk("perf_rst_hold", 128'(o_hc[0]), 128'd0);
`endif

        @(negedge clk);
        live = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
